// File: rtl/div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_pkg                                                    |
// | Description : Shared constants for the multi-cycle divider: FSM state    |
// |               encodings, handshake levels, ALU op codes and bus widths.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package div_pkg;

    // Register bus widths shared with the rest of the core
    localparam int REG_BUS_W        = 32;
    localparam int DOUBLE_REG_BUS_W = 64;
    localparam int DEFAULT_DATA_W   = REG_BUS_W;

    // Divider FSM state encoding
    localparam logic [1:0] DIV_FREE    = 2'b00;
    localparam logic [1:0] DIV_BY_ZERO = 2'b01;
    localparam logic [1:0] DIV_ON      = 2'b10;
    localparam logic [1:0] DIV_END     = 2'b11;

    // Handshake levels
    localparam logic RST_ENABLE           = 1'b1;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    // ex-facing ALU op codes that route to this unit
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_if                                                     |
// | Description : Request/response bundle between the execute stage and the  |
// |               divider. ex is the master, div is the slave.               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface div_if
    import div_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) ();

    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface : div_if
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div                                                        |
// | Description : Radix-2 restoring divider, one quotient bit per cycle.     |
// |               Handles DIV/DIVU, divide-by-zero and flush annulment.      |
// |               result = {remainder, quotient}, registered.                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module div
    import div_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  wire logic clk,
    input  wire logic rst,
    div_if.slave      bus
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int WORK_W = 2 * DATA_W + 1;

    // Two's-complement negate when requested; used both for taking operand
    // magnitudes on load and for restoring signs after the last iteration.
    function automatic logic [DATA_W-1:0] cond_negate(
        input logic [DATA_W-1:0] value,
        input logic              neg
    );
        return neg ? (~value + 1'b1) : value;
    endfunction

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;

    // Working register layout: [2W:W+1] remainder, [W] scratch, [W-1:0] quotient
    logic [WORK_W-1:0]   r_work,       w_work_nxt;
    logic [CNT_W-1:0]    r_cnt,        w_cnt_nxt;
    logic [DATA_W-1:0]   r_divisor,    w_divisor_nxt;
    logic                r_neg_quot,   w_neg_quot_nxt;
    logic                r_neg_rem,    w_neg_rem_nxt;
    logic [2*DATA_W-1:0] r_result,     w_result_nxt;
    logic                r_ready,      w_ready_nxt;

    logic                w_accept;
    logic                w_last;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;
    logic [DATA_W-1:0]   w_fix_quot;
    logic [DATA_W-1:0]   w_fix_rem;
    logic                w_op1_neg;
    logic                w_op2_neg;

    assign w_accept   = bus.start_i && !bus.annul_i;
    assign w_last     = (r_cnt == CNT_W'(DATA_W));
    // Trial subtract of the divisor from the upper half; MSB is the borrow
    assign w_diff     = {1'b0, r_work[2*DATA_W-1:DATA_W]} - {1'b0, r_divisor};
    assign w_quot     = r_work[DATA_W-1:0];
    assign w_rem      = r_work[WORK_W-1:DATA_W+1];
    assign w_fix_quot = cond_negate(w_quot, r_neg_quot);
    assign w_fix_rem  = cond_negate(w_rem, r_neg_rem);
    assign w_op1_neg  = bus.signed_div_i && bus.opdata1_i[DATA_W-1];
    assign w_op2_neg  = bus.signed_div_i && bus.opdata2_i[DATA_W-1];

    // State register
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state <= DIV_FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection; annul only aborts work in flight, never a result
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_FREE: begin
                if (w_accept) begin
                    w_state_nxt = (bus.opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                w_state_nxt = bus.annul_i ? DIV_FREE : DIV_END;
            end
            DIV_ON: begin
                if (bus.annul_i) begin
                    w_state_nxt = DIV_FREE;
                end else if (w_last) begin
                    w_state_nxt = DIV_END;
                end
            end
            DIV_END: begin
                w_state_nxt = (bus.start_i == DIV_START) ? DIV_END : DIV_FREE;
            end
            default: w_state_nxt = DIV_FREE;
        endcase
    end

    // Datapath and registered-output next values for each state
    always_comb begin
        w_work_nxt     = r_work;
        w_cnt_nxt      = r_cnt;
        w_divisor_nxt  = r_divisor;
        w_neg_quot_nxt = r_neg_quot;
        w_neg_rem_nxt  = r_neg_rem;
        w_result_nxt   = r_result;
        w_ready_nxt    = r_ready;
        case (r_state)
            DIV_FREE: begin
                w_result_nxt = '0;
                w_ready_nxt  = DIV_RESULT_NOT_READY;
                w_cnt_nxt    = '0;
                if (w_accept) begin
                    w_neg_quot_nxt = w_op1_neg ^ w_op2_neg;
                    w_neg_rem_nxt  = w_op1_neg;
                    w_divisor_nxt  = cond_negate(bus.opdata2_i, w_op2_neg);
                    w_work_nxt     = {{DATA_W{1'b0}},
                                      cond_negate(bus.opdata1_i, w_op1_neg), 1'b0};
                end
            end
            DIV_BY_ZERO: begin
                w_cnt_nxt = '0;
                if (!bus.annul_i) begin
                    w_work_nxt = '0;
                end
            end
            DIV_ON: begin
                if (bus.annul_i) begin
                    w_cnt_nxt = '0;
                end else if (w_last) begin
                    // Sign fix-up edge: publish the result straight away
                    w_work_nxt   = {w_fix_rem, 1'b0, w_fix_quot};
                    w_result_nxt = {w_fix_rem, w_fix_quot};
                    w_ready_nxt  = DIV_RESULT_READY;
                    w_cnt_nxt    = '0;
                end else begin
                    if (w_diff[DATA_W]) begin
                        w_work_nxt = {r_work[WORK_W-2:0], 1'b0};
                    end else begin
                        w_work_nxt = {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
                    end
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DIV_END: begin
                if (bus.start_i == DIV_START) begin
                    w_result_nxt = {w_rem, w_quot};
                    w_ready_nxt  = DIV_RESULT_READY;
                end else begin
                    w_result_nxt = '0;
                    w_ready_nxt  = DIV_RESULT_NOT_READY;
                end
            end
            default: begin
                w_result_nxt = '0;
                w_ready_nxt  = DIV_RESULT_NOT_READY;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_work     <= '0;
            r_cnt      <= '0;
            r_divisor  <= '0;
            r_neg_quot <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_result   <= '0;
            r_ready    <= DIV_RESULT_NOT_READY;
        end else begin
            r_work     <= w_work_nxt;
            r_cnt      <= w_cnt_nxt;
            r_divisor  <= w_divisor_nxt;
            r_neg_quot <= w_neg_quot_nxt;
            r_neg_rem  <= w_neg_rem_nxt;
            r_result   <= w_result_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;

endmodule : div
`default_nettype wire

// File: tb/tb_div.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_div                                                     |
// | Description : Self-checking bench for the divider: directed corner cases |
// |               plus random operands against an arithmetic reference.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_div;
    import div_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    // Free-running clock
    always #5 clk = ~clk;

    div_if #(.DATA_W(W)) bus ();

    div #(.DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: truncating division in 64-bit arithmetic, 0/0 on zero divisor
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // One complete operation: start held through the result, then released
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input int hold, input bit scramble);
        logic [63:0] exp;
        int          lat;
        bit          early;
        exp   = model(a, b, s);
        lat   = (b == 32'd0) ? 3 : 34;
        early = 1'b0;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = s;
        bus.start_i      = 1'b1;
        for (int e = 1; e < lat; e++) begin
            step();
            if (bus.ready_o !== 1'b0) early = 1'b1;
            if (scramble && e == 1) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~s;
            end
        end
        check({tag, "_not_early"}, {63'd0, early}, 64'd0);
        step();
        check({tag, "_ready"}, {63'd0, bus.ready_o}, 64'd1);
        check({tag, "_result"}, bus.result_o, exp);
        for (int h = 0; h < hold; h++) begin
            step();
            check({tag, "_hold"}, {bus.result_o[63:1], bus.ready_o}, {exp[63:1], 1'b1});
            check({tag, "_hold_lsb"}, {63'd0, bus.result_o[0]}, {63'd0, exp[0]});
        end
        bus.start_i = 1'b0;
        step();
        check({tag, "_release_ready"}, {63'd0, bus.ready_o}, 64'd0);
        check({tag, "_release_result"}, bus.result_o, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        bit          seen;

        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        step();
        step();
        check("reset_ready", {63'd0, bus.ready_o}, 64'd0);
        check("reset_result", bus.result_o, 64'd0);
        rst = 1'b0;
        step();

        // Directed cases
        run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 0, 1'b0);
        run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
        run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b0);
        run_div("div_by_zero", 32'h1234_5678, 32'd0, 1'b0, 0, 1'b0);
        run_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
        run_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 5, 1'b0);
        run_div("divu_max_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);

        // Annul on edge 10 of an operation
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.signed_div_i = 1'b0;
        bus.start_i      = 1'b1;
        for (int e = 1; e < 10; e++) step();
        bus.annul_i = 1'b1;
        step();
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) seen = 1'b1;
        end
        check("annul_no_result", {63'd0, seen}, 64'd0);
        run_div("after_annul_9_3", 32'd9, 32'd3, 1'b0, 0, 1'b0);

        // Annul while waiting on a divide-by-zero
        bus.opdata1_i = 32'd5;
        bus.opdata2_i = 32'd0;
        bus.start_i   = 1'b1;
        step();
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        step();
        bus.annul_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus.ready_o !== 1'b0) seen = 1'b1;
        end
        check("annul_dbz_no_ready", {63'd0, seen}, 64'd0);

        // Reset on edge 20, start still held afterwards
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.signed_div_i = 1'b0;
        bus.start_i      = 1'b1;
        for (int e = 1; e < 20; e++) step();
        rst = 1'b1;
        step();
        check("rst_mid_ready", {63'd0, bus.ready_o}, 64'd0);
        check("rst_mid_result", bus.result_o, 64'd0);
        rst = 1'b0;
        run_div("after_rst_100_7", 32'd100, 32'd7, 1'b0, 0, 1'b0);

        // Reset while a result is being presented
        bus.opdata1_i    = 32'hFFFF_FFF9;
        bus.opdata2_i    = 32'd3;
        bus.signed_div_i = 1'b1;
        bus.start_i      = 1'b1;
        for (int e = 1; e <= 35; e++) step();
        check("pre_rst_ready", {63'd0, bus.ready_o}, 64'd1);
        rst = 1'b1;
        step();
        check("rst_end_ready", {63'd0, bus.ready_o}, 64'd0);
        check("rst_end_result", bus.result_o, 64'd0);
        rst = 1'b0;
        run_div("after_rst_m7_3", 32'hFFFF_FFF9, 32'd3, 1'b1, 0, 1'b0);

        // Random operands; inputs scrambled after the start edge
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            run_div($sformatf("rand%0d", n), ra, rb, rs, n % 3, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_div
`default_nettype wire

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
- Sits beside the execute stage. ex drives start/operands and holds the pipeline stalled until ready_o. It then consumes result_o and writes it to HI/LO.
- Supports signed and unsigned division, divide-by-zero, and annulment on pipeline flush.

Parameters:
DATA_W, 32, operand width; iteration count equals DATA_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high (`RstEnable = 1'b1)
signed_div_i  input  1  1 = signed DIV, 0 = DIVU
opdata1_i  input  DATA_W  dividend
opdata2_i  input  DATA_W  divisor
start_i  input  1  `DivStart request from ex; held high until ready_o is observed
annul_i  input  1  abort the current division (flush/exception)
result_o  output  2*DATA_W  {remainder, quotient}; registered
ready_o  output  1  `DivResultReady when result_o is valid; registered

Behaviour:
- Reset is synchronous and active-high; it has priority over every other input in any state.
  - On reset: state=DivFree, cnt=0, result_o=0, ready_o=0.
- Operands and signed_div_i are captured on the start edge. Later changes to them are ignored until the next start.
- DivFree:
  - Start accepted when start_i=1 and annul_i=0.
  - If opdata2_i==0, go to DivByZero. Otherwise go to DivOn with cnt=0.
  - For signed ops, negative operands are converted to magnitude (two's complement) before loading.
  - Working register: dividend={DATA_W zeros, |dividend|, 1'b0}.
  - ready_o=0 and result_o=0 while idle.
- DivByZero: the next edge sets the working register to 0 and goes to DivEnd. Result is 0/0.
- DivOn, one iteration per edge:
  - Compute diff = upper half of the working register minus |divisor|, at DATA_W+1 bits.
  - If the borrow is set, shift left and insert 0. Otherwise replace the upper half with diff, shift left and insert 1.
  - cnt increments each iteration.
  - When cnt==DATA_W, the next edge applies the sign fix-up and goes to DivEnd. No iteration happens on that edge.
- Sign fix-up (signed only):
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the dividend's sign.
  - Example: 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0. It wraps with no trap.
- DivEnd:
  - result_o={rem, quot} and ready_o=1, both registered.
  - Stays here while start_i=1; result_o is held stable.
  - When start_i=0, the next edge goes to DivFree, ready_o=0, result_o=0.
- annul_i=1 in DivOn or DivByZero: the next edge goes to DivFree with cnt=0. ready_o stays 0 and no result is produced.
- annul_i in DivEnd has no effect; exit is governed by start_i.
- Latency, counting the edge that samples start as edge 1:
  - Normal division: ready_o is high after edge 34 (1 load + 32 iterations + 1 fix-up).
  - Divide-by-zero: ready_o is high after edge 3.
- There is no back-to-back issue. At least one DivFree cycle is required between operations.
- start_i rising while busy is not a new request; start_i is level-sensitive and only sampled in DivFree.
- Unsigned ops never apply the fix-up.
  - Example: DIVU 0xFFFFFFFF/1 gives q=0xFFFFFFFF, r=0.

Decomposition:
- The following constants go in defines.v:
  - DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11
  - DivResultReady/DivResultNotReady
  - DivStart/DivStop
  - The ex-facing AluOp codes EXE_DIV_OP/EXE_DIVU_OP
- Reuse the existing RegBus and DoubleRegBus widths.
- No sub-module is required. The magnitude/negate helper stays inline as a function.
- ex owns the stall_req and start handshake; div owns only the arithmetic FSM.

Test Plan:
- Unsigned: opdata1=100, opdata2=7, signed=0, start held → ready_o=1 after edge 34, result_o={32'd2, 32'd14}. start low → DivFree, ready_o=0 next edge.
- Signed: -7/2 (0xFFFFFFF9, 0x00000002) → q=0xFFFFFFFD, r=0xFFFFFFFF. Also 7/-2 → q=0xFFFFFFFD, r=0x00000001.
- Divide-by-zero: 0x12345678/0, start held → ready_o=1 after edge 3, result_o=64'h0.
- Annul: start 100/7, pulse annul_i on edge 10 → DivFree next edge, ready_o never rises. A new start 9/3 then yields q=3, r=0 after 34 edges.
- Boundary: signed 0x80000000/0xFFFFFFFF → {0, 0x80000000}. Unsigned 0xFFFFFFFF/1 → {0, 0xFFFFFFFF}. Hold start 5 extra cycles in DivEnd → result_o stable.
- Reset mid-op: assert rst at edge 20 of a division → ready_o=0, result_o=0 next edge. With start still high after reset release, a fresh division begins and completes correctly.
